// File: rtl/fix_parser_pkg.sv
// Shared definitions for the FIX tag/value FIFO.
//   FIX_TAG_WIDTH   : default tag field width
//   FIX_VAL_WIDTH   : default value field width
//   fix_tv_entry_t  : one stored entry, {eom, tag, val}, eom in the MSB
//   FIX_ENTRY_WIDTH : packed width of fix_tv_entry_t
package fix_parser_pkg;

   localparam int FIX_TAG_WIDTH = 32;
   localparam int FIX_VAL_WIDTH = 64;

   typedef struct packed {
      logic                     eom;
      logic [FIX_TAG_WIDTH-1:0] tag;
      logic [FIX_VAL_WIDTH-1:0] val;
   } fix_tv_entry_t;

   localparam int FIX_ENTRY_WIDTH = $bits(fix_tv_entry_t);

endpackage

// File: rtl/fix_parser_tagval_ram.sv
// Simple dual-port entry storage for the FIX tag/value FIFO.
// Synchronous write, asynchronous (combinational) read so the FIFO head is
// available in the same cycle as its read address.
// Ports:
//   clk      : clock
//   wr_en    : write strobe
//   wr_addr  : write address
//   wr_data  : write data
//   rd_addr  : read address
//   rd_data  : read data (combinational from rd_addr)
module fix_parser_tagval_ram
   import fix_parser_pkg::*;
#(
   parameter int DATA_WIDTH = FIX_ENTRY_WIDTH,
   parameter int ADDR_WIDTH = 8
) (
   input  logic                  clk,
   input  logic                  wr_en,
   input  logic [ADDR_WIDTH-1:0] wr_addr,
   input  logic [DATA_WIDTH-1:0] wr_data,
   input  logic [ADDR_WIDTH-1:0] rd_addr,
   output logic [DATA_WIDTH-1:0] rd_data
);

   logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_addr] <= wr_data;
      end
   end

   assign rd_data = mem[rd_addr];

endmodule

// File: rtl/fix_parser_tagval_fifo.sv
// Message-aware tag/value FIFO between the FIX field parser and decode.
// Entries are written speculatively; downstream only sees them once the
// parser commits the message. Abort (or commit after an overflow) rolls the
// speculative write pointer back to the commit pointer.
//
// Valid/ready semantics: a push happens on any cycle with wr_en_i=1 and
// full_o=0; a pop happens on any cycle with rd_en_i=1 and valid_o=1. The
// head (tag_o/val_o/eom_o) is meaningful whenever valid_o=1 and is held
// until popped.
//
// Ports:
//   clk, rst       : clock, synchronous active-high reset
//   wr_en_i        : push {eom_i, tag_i, val_i} speculatively
//   commit_i       : publish all speculative entries
//   abort_i        : discard all speculative entries (wins over commit_i)
//   rd_en_i        : pop head entry
//   valid_o/empty_o: committed head present / absent
//   tag_o/val_o/eom_o : head entry (first-word fall-through)
//   full_o, almost_full_o : registered occupancy flags
//   drop_o         : one-cycle pulse when a speculative message is discarded
//   msg_cnt_o      : committed messages not yet fully read
module fix_parser_tagval_fifo
   import fix_parser_pkg::*;
#(
   parameter int TAG_WIDTH    = FIX_TAG_WIDTH,
   parameter int VAL_WIDTH    = FIX_VAL_WIDTH,
   parameter int ADDR_WIDTH   = 8,
   parameter int AFULL_THRESH = 240
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  wr_en_i,
   input  logic [TAG_WIDTH-1:0]  tag_i,
   input  logic [VAL_WIDTH-1:0]  val_i,
   input  logic                  eom_i,
   input  logic                  commit_i,
   input  logic                  abort_i,
   input  logic                  rd_en_i,
   output logic                  valid_o,
   output logic [TAG_WIDTH-1:0]  tag_o,
   output logic [VAL_WIDTH-1:0]  val_o,
   output logic                  eom_o,
   output logic                  empty_o,
   output logic                  full_o,
   output logic                  almost_full_o,
   output logic                  drop_o,
   output logic [ADDR_WIDTH:0]   msg_cnt_o
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam int EW = 1 + TAG_WIDTH + VAL_WIDTH;
   localparam logic [PW-1:0] DEPTH_P = PW'(2**ADDR_WIDTH);
   localparam logic [PW-1:0] AFULL_P = PW'(AFULL_THRESH);
   localparam logic [PW-1:0] ONE_P   = PW'(1);

   logic [PW-1:0] wr_ptr, cmt_ptr, rd_ptr, msg_cnt;
   logic [PW-1:0] wr_ptr_nx, cmt_ptr_nx, rd_ptr_nx, msg_cnt_nx, occ_nx;
   logic          ovf, seen_eom, full_q, afull_q, drop_q;
   logic          ovf_nx, seen_eom_nx;
   logic          wr_ok, rd_ok, do_abort, do_commit, spec_any;
   logic          cnt_inc, cnt_dec;
   logic [EW-1:0] rd_data;

   assign valid_o  = (rd_ptr != cmt_ptr);
   assign empty_o  = !valid_o;
   assign full_o   = full_q;
   assign almost_full_o = afull_q;
   assign drop_o   = drop_q;
   assign msg_cnt_o = msg_cnt;

   assign eom_o = rd_data[EW-1];
   assign tag_o = rd_data[VAL_WIDTH +: TAG_WIDTH];
   assign val_o = rd_data[VAL_WIDTH-1:0];

   assign wr_ok    = wr_en_i && !full_q;
   assign rd_ok    = rd_en_i && valid_o;
   // Committing a message that lost an entry to overflow would publish a
   // corrupt message, so it is rolled back exactly like an abort.
   assign do_abort  = abort_i || (commit_i && ovf);
   assign do_commit = commit_i && !do_abort;
   assign spec_any  = (wr_ptr != cmt_ptr);

   // Only a commit whose span holds an eom closes a message.
   assign cnt_inc = do_commit && (seen_eom || (wr_ok && eom_i));
   assign cnt_dec = rd_ok && eom_o;

   always_comb begin
      wr_ptr_nx   = wr_ptr;
      cmt_ptr_nx  = cmt_ptr;
      rd_ptr_nx   = rd_ptr;
      msg_cnt_nx  = msg_cnt;
      ovf_nx      = ovf;
      seen_eom_nx = seen_eom;

      if (wr_ok) begin
         wr_ptr_nx = wr_ptr + ONE_P;
      end
      if (do_abort) begin
         wr_ptr_nx = cmt_ptr;
      end
      // Commit takes the post-write pointer so a same-cycle write is published.
      if (do_commit) begin
         cmt_ptr_nx = wr_ptr_nx;
      end
      if (rd_ok) begin
         rd_ptr_nx = rd_ptr + ONE_P;
      end

      if (cnt_inc && !cnt_dec) begin
         msg_cnt_nx = msg_cnt + ONE_P;
      end else if (!cnt_inc && cnt_dec) begin
         msg_cnt_nx = msg_cnt - ONE_P;
      end

      if (wr_en_i && full_q) begin
         ovf_nx = 1'b1;
      end
      if (do_abort) begin
         ovf_nx = 1'b0;
      end

      if (wr_ok && eom_i) begin
         seen_eom_nx = 1'b1;
      end
      if (do_abort || do_commit) begin
         seen_eom_nx = 1'b0;
      end
   end

   assign occ_nx = wr_ptr_nx - rd_ptr_nx;

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr   <= '0;
         cmt_ptr  <= '0;
         rd_ptr   <= '0;
         msg_cnt  <= '0;
         ovf      <= 1'b0;
         seen_eom <= 1'b0;
         full_q   <= 1'b0;
         afull_q  <= 1'b0;
         drop_q   <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr_nx;
         cmt_ptr  <= cmt_ptr_nx;
         rd_ptr   <= rd_ptr_nx;
         msg_cnt  <= msg_cnt_nx;
         ovf      <= ovf_nx;
         seen_eom <= seen_eom_nx;
         full_q   <= (occ_nx == DEPTH_P);
         afull_q  <= (occ_nx >= AFULL_P);
         drop_q   <= do_abort && spec_any;
      end
   end

   fix_parser_tagval_ram #(
      .DATA_WIDTH (EW),
      .ADDR_WIDTH (ADDR_WIDTH)
   ) u_ram (
      .clk     (clk),
      .wr_en   (wr_ok && !do_abort),
      .wr_addr (wr_ptr[ADDR_WIDTH-1:0]),
      .wr_data ({eom_i, tag_i, val_i}),
      .rd_addr (rd_ptr[ADDR_WIDTH-1:0]),
      .rd_data (rd_data)
   );

endmodule

// File: tb/tb_fix_parser_tagval_fifo.sv
// Self-checking bench for fix_parser_tagval_fifo (depth 8, almost-full at 6).
// A queue-based model (committed queue + speculative queue) predicts every
// output; a negedge process compares each cycle. Directed sequences add
// hand-computed expectations before a randomized message phase.
module tb_fix_parser_tagval_fifo;

   localparam int TW = 32;
   localparam int VW = 64;
   localparam int AW = 3;
   localparam int DEPTH = 8;
   localparam int AFULL = 6;
   localparam int EW = 1 + TW + VW;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic          wr_en = 1'b0, eom = 1'b0, commit = 1'b0, abort = 1'b0, rd_en = 1'b0;
   logic [TW-1:0] tag = '0;
   logic [VW-1:0] val = '0;

   logic          valid_o, eom_o, empty_o, full_o, almost_full_o, drop_o;
   logic [TW-1:0] tag_o;
   logic [VW-1:0] val_o;
   logic [AW:0]   msg_cnt_o;

   fix_parser_tagval_fifo #(
      .TAG_WIDTH (TW), .VAL_WIDTH (VW), .ADDR_WIDTH (AW), .AFULL_THRESH (AFULL)
   ) dut (
      .clk (clk), .rst (rst),
      .wr_en_i (wr_en), .tag_i (tag), .val_i (val), .eom_i (eom),
      .commit_i (commit), .abort_i (abort), .rd_en_i (rd_en),
      .valid_o (valid_o), .tag_o (tag_o), .val_o (val_o), .eom_o (eom_o),
      .empty_o (empty_o), .full_o (full_o), .almost_full_o (almost_full_o),
      .drop_o (drop_o), .msg_cnt_o (msg_cnt_o)
   );

   int n_tests = 0;
   int n_fail  = 0;

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // ---------------- behavioural model ----------------
   logic [EW-1:0] exp_q[$];   // committed, visible entries
   logic [EW-1:0] spec_q[$];  // speculative entries
   logic          m_ovf = 1'b0, m_seen = 1'b0, m_drop = 1'b0;
   int            m_cnt = 0;
   int            m_occ;
   logic          m_full, m_abort, m_had_spec, m_wr_acc;
   logic [EW-1:0] m_e;

   always @(posedge clk) begin
      if (rst) begin
         exp_q.delete();
         spec_q.delete();
         m_ovf = 1'b0; m_seen = 1'b0; m_drop = 1'b0; m_cnt = 0;
      end else begin
         m_occ      = exp_q.size() + spec_q.size();
         m_full     = (m_occ == DEPTH);
         m_abort    = abort || (commit && m_ovf);
         m_had_spec = (spec_q.size() != 0);
         m_wr_acc   = wr_en && !m_full;
         m_drop     = m_abort && m_had_spec;
         if (rd_en && exp_q.size() > 0) begin
            m_e = exp_q.pop_front();
            if (m_e[EW-1]) m_cnt--;
         end
         if (m_wr_acc) spec_q.push_back({eom, tag, val});
         if (wr_en && m_full) m_ovf = 1'b1;
         if (m_abort) begin
            spec_q.delete();
            m_ovf = 1'b0;
            m_seen = 1'b0;
         end else if (commit) begin
            if (m_seen || (m_wr_acc && eom)) m_cnt++;
            while (spec_q.size() > 0) exp_q.push_back(spec_q.pop_front());
            m_seen = 1'b0;
         end else if (m_wr_acc && eom) begin
            m_seen = 1'b1;
         end
      end
   end

   // ---------------- compare process ----------------
   logic [AW:0] exp_cnt;
   always @(negedge clk) begin
      m_occ = exp_q.size() + spec_q.size();
      exp_cnt = AW'(0);
      exp_cnt = m_cnt[AW:0];
      chk("valid", valid_o, exp_q.size() > 0);
      chk("empty", empty_o, exp_q.size() == 0);
      chk("full", full_o, m_occ == DEPTH);
      chk("almost_full", almost_full_o, m_occ >= AFULL);
      chk("drop", drop_o, m_drop);
      chk("msg_cnt", msg_cnt_o, exp_cnt);
      if (exp_q.size() > 0) begin
         chk("head", {eom_o, tag_o, val_o}, exp_q[0]);
      end
   end

   // ---------------- driver tasks ----------------
   // Called at posedge+2; applies inputs for one edge and returns at the
   // following posedge+2 with inputs cleared.
   task automatic step(input logic w, input logic [TW-1:0] t, input logic e,
                       input logic cm, input logic ab, input logic rd);
      wr_en = w; tag = t; val = {~t, t}; eom = e;
      commit = cm; abort = ab; rd_en = rd;
      @(posedge clk); #2;
      wr_en = 0; eom = 0; commit = 0; abort = 0; rd_en = 0;
   endtask

   task automatic wr_step(input logic [TW-1:0] t, input logic e);
      step(1'b1, t, e, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle_step();
      step(1'b0, '0, 1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(posedge clk); #2;
      rst = 1'b0;
   endtask

   int next_tag;
   int pend;
   logic r_w, r_e, r_c, r_a, r_r;

   initial begin
      @(posedge clk); @(posedge clk); #2;
      rst = 1'b0;
      chk("rst_valid", valid_o, 1'b0);
      chk("rst_empty", empty_o, 1'b1);
      chk("rst_full", full_o, 1'b0);
      chk("rst_afull", almost_full_o, 1'b0);
      chk("rst_drop", drop_o, 1'b0);
      chk("rst_cnt", msg_cnt_o, 4'd0);

      // Commit visibility
      wr_step(8, 0); wr_step(35, 0); wr_step(10, 1);
      chk("t1_uncommitted", valid_o, 1'b0);
      step(0, 0, 0, 1, 0, 0);
      chk("t1_valid", valid_o, 1'b1);
      chk("t1_tag", tag_o, 8);
      chk("t1_cnt", msg_cnt_o, 4'd1);
      step(0, 0, 0, 0, 0, 1);
      chk("t1_tag2", tag_o, 35);
      step(0, 0, 0, 0, 0, 1);
      chk("t1_tag3", tag_o, 10);
      chk("t1_eom3", eom_o, 1'b1);
      step(0, 0, 0, 0, 0, 1);
      chk("t1_cnt_end", msg_cnt_o, 4'd0);
      chk("t1_empty_end", empty_o, 1'b1);

      // Abort
      wr_step(20, 0); wr_step(21, 0);
      step(0, 0, 0, 0, 1, 0);
      chk("t2_drop", drop_o, 1'b1);
      chk("t2_valid", valid_o, 1'b0);
      idle_step();
      chk("t2_drop_pulse", drop_o, 1'b0);
      step(1, 55, 1, 1, 0, 0);
      chk("t2_next_tag", tag_o, 55);
      chk("t2_next_cnt", msg_cnt_o, 4'd1);
      step(0, 0, 0, 0, 0, 1);
      chk("t2_empty", empty_o, 1'b1);

      // Abort beats commit; write with commit is included in order
      wr_step(66, 1);
      step(0, 0, 0, 1, 1, 0);
      chk("t4_abort_wins_drop", drop_o, 1'b1);
      chk("t4_abort_wins_valid", valid_o, 1'b0);
      chk("t4_abort_wins_cnt", msg_cnt_o, 4'd0);
      wr_step(70, 0);
      step(1, 71, 1, 1, 0, 0);
      chk("t4_wc_tag", tag_o, 70);
      step(0, 0, 0, 0, 0, 1);
      chk("t4_wc_tag2", tag_o, 71);
      step(0, 0, 0, 0, 0, 1);
      chk("t4_wc_empty", empty_o, 1'b1);

      // Overflow
      for (int i = 0; i < 8; i++) begin
         wr_step(100 + i, 0);
         if (i == 4) chk("t3_afull_below", almost_full_o, 1'b0);
         if (i == 5) chk("t3_afull_at", almost_full_o, 1'b1);
         if (i == 6) chk("t3_full_below", full_o, 1'b0);
      end
      chk("t3_full", full_o, 1'b1);
      wr_step(108, 1);
      chk("t3_full_hold", full_o, 1'b1);
      step(0, 0, 0, 1, 0, 0);
      chk("t3_drop", drop_o, 1'b1);
      chk("t3_empty", empty_o, 1'b1);
      chk("t3_full_clr", full_o, 1'b0);
      chk("t3_cnt", msg_cnt_o, 4'd0);

      // Wrap: occupancy swings 3 <-> 6 across the almost-full threshold
      next_tag = 200;
      wr_step(200, 0); wr_step(201, 0); step(1, 202, 1, 1, 0, 0);
      for (int r = 0; r < 10; r++) begin
         wr_step(203 + 3 * r, 0); wr_step(204 + 3 * r, 0);
         step(1, 205 + 3 * r, 1, 1, 0, 0);
         chk("t5_afull_hi", almost_full_o, 1'b1);
         chk("t5_cnt_hi", msg_cnt_o, 4'd2);
         for (int k = 0; k < 3; k++) begin
            chk("t5_order", tag_o, next_tag);
            next_tag++;
            step(0, 0, 0, 0, 0, 1);
         end
         chk("t5_afull_lo", almost_full_o, 1'b0);
      end
      for (int k = 0; k < 3; k++) step(0, 0, 0, 0, 0, 1);
      chk("t5_drained", empty_o, 1'b1);

      // Reset mid-message
      wr_step(1, 0); step(1, 2, 1, 1, 0, 0); wr_step(3, 0);
      do_reset();
      chk("t6_valid", valid_o, 1'b0);
      chk("t6_empty", empty_o, 1'b1);
      chk("t6_cnt", msg_cnt_o, 4'd0);
      chk("t6_drop", drop_o, 1'b0);

      // Randomized message traffic; at most one eom per committed span
      pend = 0;
      for (int c = 0; c < 4000; c++) begin
         if ($urandom_range(0, 999) == 0) begin
            do_reset();
            pend = 0;
         end else begin
            r_w = ($urandom_range(0, 9) < 6);
            r_e = r_w && (pend == 0) && ($urandom_range(0, 3) == 0);
            r_c = (pend != 0) ? ($urandom_range(0, 9) < 4) : ($urandom_range(0, 99) < 3);
            r_a = ($urandom_range(0, 99) < 3);
            r_r = ($urandom_range(0, 9) < 4);
            if (r_e) pend = 1;
            if (r_c || r_a) pend = 0;
            step(r_w, $urandom, r_e, r_c, r_a, r_r);
         end
      end

      @(posedge clk); #2;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
